muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//   Multi-cycle sequencer for RV32M MUL/DIV/REM/DIVU in the EX stage. Accepts one op from
//   EX, holds the pipeline via stall_o, runs an iterative shift-add multiply or restoring
//   divide over XLEN cycles, then returns result_o with a one-cycle done_o. Sits beside the
//   main ALU; the ALU control decode raises start_i when it sees an M-extension funct.
// PARAMETERS
//   XLEN   32   operand/result width
//   CNT_W  5    iteration counter width; must equal clog2(XLEN)
// PORTS
//   clk_i     in   1     clock, rising edge
//   rst_i     in   1     reset, synchronous, active-low
//   start_i   in   1     EX holds an M-op with valid operands
//   op_i      in   2     00 MUL (low XLEN bits), 01 DIV, 10 REM, 11 DIVU
//   rs1_i     in   XLEN  dividend / multiplicand
//   rs2_i     in   XLEN  divisor / multiplier
//   flush_i   in   1     squash the in-flight op (branch/exception)
//   stall_o   out  1     freeze IF/ID/EX
//   done_o    out  1     one-cycle pulse; result_o valid
//   result_o  out  XLEN  result; held until the next accepted start
// BEHAVIOUR
//   Reset (rst_i=0 at an edge): state=IDLE, cnt=0, all internal regs=0; done_o=0, result_o=0.
//     stall_o=0 after reset. Reset mid-op abandons it with no done_o.
//   FSM states IDLE, BUSY, DONE:
//     IDLE: start_i=1 & flush_i=0 -> latch op and operands, cnt=0, go BUSY.
//     BUSY: one iteration per cycle, cnt++. After iteration XLEN-1 (cnt==XLEN-1) go DONE.
//     DONE: done_o=1 and result_o valid for this cycle. Go IDLE next. start_i is ignored.
//   stall_o = (IDLE & start_i & ~flush_i) | BUSY. Combinational; 0 in DONE, so EX
//     advances in the same cycle it captures result_o.
//   Latency: start accepted in cycle 0; BUSY in cycles 1..XLEN; DONE in cycle XLEN+1.
//     The earliest next accept is cycle XLEN+2.
//   MUL: 2*XLEN accumulator, add-and-shift. Keep the low XLEN bits; sign-agnostic.
//   DIV/REM: divide the magnitudes with the restoring algorithm. Quotient sign =
//     sign(rs1)^sign(rs2); remainder sign = sign(rs1). Fix-up happens at the BUSY->DONE edge.
//   DIVU: unsigned restoring divide, no fix-up.
//   Divide by zero (rs2=0): DIV/DIVU -> all ones; REM -> rs1. Takes full latency unless
//     the optional feature is enabled.
//   Overflow: DIV -2^31/-1 -> 32'h8000_0000. REM -2^31/-1 -> 0.
//   flush_i=1 in BUSY or DONE: go IDLE next cycle. No done_o; result_o keeps its old value.
//     flush_i in IDLE blocks the accept.
//   start_i and flush_i in the same IDLE cycle: flush wins, nothing accepted.
//   result_o changes only at the entry to DONE.
// CONFIGURATION
//   MULDIV_ZERO_BYPASS_EN defined: when an op is accepted with a zero operand, the FSM goes
//     IDLE->DONE directly and done_o arrives in cycle 1. Zero operand means rs1=0 or rs2=0
//     for MUL, or rs2=0 for DIV/REM/DIVU.
//     Result values: MUL -> 0; div-by-zero -> the values listed above. stall_o is high in
//     cycle 0 only.
//   Macro undefined: every op takes the full XLEN+1 latency.
// TESTING
//   1 MUL 7*-3, start cycle 0: stall_o=1 cycles 0..32; done_o=1 at cycle 33;
//     result_o=32'hFFFF_FFEB.
//   2 DIV -7/2 -> result_o=32'hFFFF_FFFD (-3). REM -7/2 -> 32'hFFFF_FFFF (-1).
//     DIVU 32'hFFFF_FFFE/2 -> 32'h7FFF_FFFF.
//   3 DIV 32'h8000_0000/32'hFFFF_FFFF -> 32'h8000_0000; REM same operands -> 0.
//   4 DIV 5/0 -> 32'hFFFF_FFFF; REM 5/0 -> 5. done_o at cycle 33, or at cycle 1 with
//     MULDIV_ZERO_BYPASS_EN.
//   5 flush_i pulse at cycle 10 of a MUL: stall_o=0 from cycle 11; no done_o; result_o
//     unchanged. A new start at cycle 12 completes normally.
//   6 rst_i=0 at cycle 5 of a DIV: next cycle state=IDLE, stall_o=0, result_o=0, no done_o.
//     Back-to-back DIVs give done_o at cycles 33 and 67.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M MUL/DIV/REM/DIVU sequencer: shift-add multiply, restoring divide.
// Optional MULDIV_ZERO_BYPASS_EN: zero-operand ops skip straight from IDLE to DONE.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_i; accept latches op and operand magnitudes
// BUSY  | one multiply/divide iteration per cycle, cnt 0..XLEN-1
// DONE  | done_o pulse, result_o valid; start_i ignored
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_DIVU = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [XLEN-1:0]  hi;
  logic [XLEN-1:0]  lo;
  logic [XLEN-1:0]  opb;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic             accept;
  logic             last_iter;
  logic             signed_op;
  logic [XLEN-1:0]  rs1_mag;
  logic [XLEN-1:0]  rs2_mag;
  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    trial;
  logic [XLEN-1:0]  hi_nx;
  logic [XLEN-1:0]  lo_nx;
  logic [XLEN-1:0]  final_res;

  assign accept    = (state == S_IDLE) & start_i & ~flush_i;
  assign last_iter = (cnt == CNT_W'(XLEN - 1));
  assign signed_op = (op_i == OP_DIV) | (op_i == OP_REM);
  assign rs1_mag   = (signed_op & rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
  assign rs2_mag   = (signed_op & rs2_i[XLEN-1]) ? -rs2_i : rs2_i;

  assign stall_o = accept | (state == S_BUSY);
  assign done_o  = (state == S_DONE) & ~flush_i;

  // MUL keeps the multiplier in lo and shifts product bits in from the top;
  // divide keeps the partial remainder in hi and shifts quotient bits into lo.
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
  assign trial   = {hi, lo[XLEN-1]} - {1'b0, opb};

  always_comb begin
    hi_nx = hi;
    lo_nx = lo;
    if (op_q == OP_MUL) begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], lo[XLEN-1:1]};
    end else if (!trial[XLEN]) begin
      hi_nx = trial[XLEN-1:0];
      lo_nx = {lo[XLEN-2:0], 1'b1};
    end else begin
      hi_nx = {hi[XLEN-2:0], lo[XLEN-1]};
      lo_nx = {lo[XLEN-2:0], 1'b0};
    end
  end

  // A zero divisor leaves the dividend magnitude in hi, so REM needs no special case.
  always_comb begin
    final_res = lo_nx;
    case (op_q)
      OP_MUL:  final_res = lo_nx;
      OP_REM:  final_res = neg_r ? -hi_nx : hi_nx;
      default: final_res = div_zero ? {XLEN{1'b1}} : (neg_q ? -lo_nx : lo_nx);
    endcase
  end

`ifdef MULDIV_ZERO_BYPASS_EN
  logic            zero_op;
  logic [XLEN-1:0] bypass_res;

  assign zero_op = (op_i == OP_MUL) ? ((rs1_i == '0) | (rs2_i == '0)) : (rs2_i == '0);

  always_comb begin
    bypass_res = {XLEN{1'b1}};
    case (op_i)
      OP_MUL:  bypass_res = '0;
      OP_REM:  bypass_res = rs1_i;
      default: bypass_res = {XLEN{1'b1}};
    endcase
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= OP_MUL;
      hi       <= '0;
      lo       <= '0;
      opb      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= op_i;
            hi       <= '0;
            lo       <= rs1_mag;
            opb      <= rs2_mag;
            neg_q    <= (op_i == OP_DIV) & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
            neg_r    <= (op_i == OP_REM) & rs1_i[XLEN-1];
            div_zero <= (rs2_i == '0);
            cnt      <= '0;
            state    <= S_BUSY;
`ifdef MULDIV_ZERO_BYPASS_EN
            if (zero_op) begin
              state    <= S_DONE;
              result_o <= bypass_res;
            end
`endif
          end
        end
        S_BUSY: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
              state    <= S_DONE;
              result_o <= final_res;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results queued at issue,
// compared when done_o pulses; latency, stall, flush and reset behaviour checked.
module tb_muldiv_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'd0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;

  muldiv_sequencer #(.XLEN(32), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
    .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, r;
    sa = a;
    sb = b;
    case (op)
      2'd0: return a * b;
      2'd1: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = sa / sb;
        return r;
      end
      2'd2: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        r = sa % sb;
        return r;
      end
      default: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_ZERO_BYPASS_EN
    if (op == 2'd0 ? (a == 0 || b == 0) : (b == 0)) return 1;
`endif
    return 33;
  endfunction

  always @(negedge clk_i) begin
    if (rst_i && done_o) begin
      if (exp_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else chk("result", result_o, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  // Drives start_i during cycle 0 and returns one edge later, in cycle 1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    op_i = op;
    rs1_i = a;
    rs2_i = b;
    start_i = 1'b1;
    cyc = 0;
    #1;
    chk("stall_c0", {31'd0, stall_o}, 32'd1);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    cyc = 1;
    if (push) begin
      last_res = model(op, a, b);
      exp_q.push_back(last_res);
    end
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int bad = 0;
    while (!done_o && cyc < 60) begin
      if (stall_o !== 1'b1) bad++;
      step();
    end
    chk({tag, "_lat"}, cyc, exp_cyc);
    chk({tag, "_stall_busy"}, bad, 0);
    chk({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
    step();
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b, 1'b1);
    wait_done(tag, exp_lat(op, a, b));
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    rst_i = 1'b1;
    step();

    run_op("mul_7x-3", 2'd0, 32'd7, 32'hFFFF_FFFD);
    chk("mul_7x-3_val", last_res, 32'hFFFF_FFEB);
    run_op("div_-7/2", 2'd1, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_-7/2", 2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op("divu", 2'd3, 32'hFFFF_FFFE, 32'd2);
    run_op("div_ovf", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_0", 2'd1, 32'd5, 32'd0);
    run_op("rem_0", 2'd2, 32'd5, 32'd0);
    run_op("rem_neg_0", 2'd2, 32'hFFFF_FF00, 32'd0);
    run_op("divu_0", 2'd3, 32'd5, 32'd0);
    run_op("mul_0", 2'd0, 32'd0, 32'd5);
    run_op("rem_7/-2", 2'd2, 32'd7, 32'hFFFF_FFFE);

    for (int i = 0; i < 8; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op("rand", op, a, b);
    end

    // flush mid-MUL: stall drops, no done, result unchanged, then a fresh start works
    issue(2'd0, 32'd123, 32'd456, 1'b0);
    while (cyc < 10) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_stall", {31'd0, stall_o}, 32'd0);
    chk("flush_done", {31'd0, done_o}, 32'd0);
    chk("flush_result", result_o, last_res);
    step();
    run_op("after_flush", 2'd0, 32'd123, 32'd456);

    start_i = 1'b1;
    flush_i = 1'b1;
    op_i = 2'd3;
    rs1_i = 32'd100;
    rs2_i = 32'd7;
    #1;
    chk("flush_blocks_stall", {31'd0, stall_o}, 32'd0);
    step();
    start_i = 1'b0;
    flush_i = 1'b0;
    chk("flush_blocks_accept", {31'd0, stall_o}, 32'd0);
    repeat (3) step();

    // reset mid-DIV
    issue(2'd1, 32'd1000, 32'd7, 1'b0);
    while (cyc < 5) step();
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    chk("rstmid_stall", {31'd0, stall_o}, 32'd0);
    chk("rstmid_result", result_o, 32'd0);
    chk("rstmid_done", {31'd0, done_o}, 32'd0);
    repeat (3) step();

    run_op("b2b_1", 2'd1, 32'd1000, 32'd7);
    run_op("b2b_2", 2'd1, 32'hFFFF_FC18, 32'd7);

    repeat (3) step();
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
